// File: rtl/alu_nibble_seq.sv
// Initiator sequencer for a nibble-serial ALU: takes one 8-bit request, drives the ALU control word, returns result + Z/N/H/C.
// Optional macro ALU_NIBBLE_SEQ_B2B_EN removes DONE and accepts the next request during HI (1 op per 3 cycles).
module alu_nibble_seq #(
  parameter int W_OP = 3
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [W_OP-1:0] req_op,
  input  logic [7:0]      req_a,
  input  logic [7:0]      req_b,
  input  logic            req_cin,
  output logic [7:0]      alu_op,
  output logic            alu_la,
  output logic            alu_lb,
  output logic            alu_sh,
  output logic            alu_oe,
  output logic            alu_r,
  output logic            alu_s,
  output logic            alu_v,
  output logic            alu_ne,
  output logic            alu_ci,
  output logic            alu_l,
  output logic            alu_h,
  input  logic [7:0]      alu_result,
  input  logic            alu_carry,
  input  logic            alu_zero,
  output logic            res_valid,
  output logic [7:0]      res_data,
  output logic            res_we,
  output logic            flag_z,
  output logic            flag_n,
  output logic            flag_h,
  output logic            flag_c
);

  localparam logic [W_OP-1:0] OP_ADD = W_OP'(0);
  localparam logic [W_OP-1:0] OP_ADC = W_OP'(1);
  localparam logic [W_OP-1:0] OP_SUB = W_OP'(2);
  localparam logic [W_OP-1:0] OP_SBC = W_OP'(3);
  localparam logic [W_OP-1:0] OP_AND = W_OP'(4);
  localparam logic [W_OP-1:0] OP_XOR = W_OP'(5);
  localparam logic [W_OP-1:0] OP_OR  = W_OP'(6);
  localparam logic [W_OP-1:0] OP_CP  = W_OP'(7);

`ifdef ALU_NIBBLE_SEQ_B2B_EN
  typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_LO, HI} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_LO, HI, DONE} state_t;
`endif

  state_t          state_q, state_d;
  logic [W_OP-1:0] op_q;
  logic [7:0]      a_q, b_q;
  logic            cin_q;
  logic            halfCarry_q;
  logic            resValid_q;
  logic [7:0]      resData_q;
  logic            resWe_q;
  logic            flagZ_q, flagN_q, flagH_q, flagC_q;

  logic isAdd, isSub, isCp, accept, funcPhase, loCarryIn;
  logic hFlag, cFlag;

  assign isAdd = (op_q == OP_ADD) || (op_q == OP_ADC);
  assign isSub = (op_q == OP_SUB) || (op_q == OP_SBC) || (op_q == OP_CP);
  assign isCp  = (op_q == OP_CP);

`ifdef ALU_NIBBLE_SEQ_B2B_EN
  assign req_ready = (state_q == IDLE) || (state_q == HI);
`else
  assign req_ready = (state_q == IDLE);
`endif
  assign accept = req_valid && req_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = LOAD_A;
      LOAD_A:  state_d = LOAD_LO;
      LOAD_LO: state_d = HI;
`ifdef ALU_NIBBLE_SEQ_B2B_EN
      HI:      state_d = req_valid ? LOAD_A : IDLE;
`else
      HI:      state_d = DONE;
      DONE:    state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Low-nibble carry in: subtraction is A + ~B + 1, so borrow-in inverts the incoming C.
  always_comb begin
    loCarryIn = 1'b0;
    case (op_q)
      OP_ADC:       loCarryIn = cin_q;
      OP_SUB, OP_CP: loCarryIn = 1'b1;
      OP_SBC:       loCarryIn = ~cin_q;
      default:      loCarryIn = 1'b0;
    endcase
  end

  assign funcPhase = (state_q == LOAD_LO) || (state_q == HI);
  assign alu_sh    = 1'b0;

  always_comb begin
    alu_op = 8'h00;
    alu_la = 1'b0;
    alu_lb = 1'b0;
    alu_oe = 1'b0;
    alu_ci = 1'b0;
    alu_l  = 1'b0;
    alu_h  = 1'b0;
    alu_r  = funcPhase && (op_q == OP_AND);
    alu_v  = funcPhase && (op_q == OP_XOR);
    alu_s  = funcPhase && (op_q == OP_OR);
    alu_ne = funcPhase && isSub;
    case (state_q)
      LOAD_A: begin
        alu_op = a_q;
        alu_la = 1'b1;
      end
      LOAD_LO: begin
        alu_op = b_q;
        alu_lb = 1'b1;
        alu_l  = 1'b1;
        alu_ci = loCarryIn;
      end
      HI: begin
        alu_h  = 1'b1;
        alu_oe = 1'b1;
        alu_ci = halfCarry_q;
      end
      default: ;
    endcase
  end

  // Subtraction reports borrows, which are the inverted ALU carries.
  always_comb begin
    hFlag = 1'b0;
    cFlag = 1'b0;
    if (isAdd) begin
      hFlag = halfCarry_q;
      cFlag = alu_carry;
    end else if (isSub) begin
      hFlag = ~halfCarry_q;
      cFlag = ~alu_carry;
    end else begin
      hFlag = (op_q == OP_AND);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      op_q        <= '0;
      a_q         <= 8'h00;
      b_q         <= 8'h00;
      cin_q       <= 1'b0;
      halfCarry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= req_op;
        a_q   <= req_a;
        b_q   <= req_b;
        cin_q <= req_cin;
      end
      if (state_q == LOAD_LO) halfCarry_q <= alu_carry;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resValid_q <= 1'b0;
      resData_q  <= 8'h00;
      resWe_q    <= 1'b0;
      flagZ_q    <= 1'b0;
      flagN_q    <= 1'b0;
      flagH_q    <= 1'b0;
      flagC_q    <= 1'b0;
    end else begin
      resValid_q <= (state_q == HI);
      if (state_q == HI) begin
        resData_q <= isCp ? a_q : alu_result;
        resWe_q   <= ~isCp;
        flagZ_q   <= alu_zero;
        flagN_q   <= isSub;
        flagH_q   <= hFlag;
        flagC_q   <= cFlag;
      end
    end
  end

  assign res_valid = resValid_q;
  assign res_data  = resData_q;
  assign res_we    = resWe_q;
  assign flag_z    = flagZ_q;
  assign flag_n    = flagN_q;
  assign flag_h    = flagH_q;
  assign flag_c    = flagC_q;

endmodule
